spi_master_stage: RTL
=====================

# spi_master_stage

SPI master shift engine that consumes the divider's `clk_div` output and turns each toggle of it into one SPI half-bit. It sits directly downstream of the programmable clock divider in the SPI path. The divider sets the SCLK rate; this block owns chip select, bit shifting and a simple valid/ready byte interface to the host logic. It runs entirely in the `clk_in` domain and uses `clk_div` only as a sampled level, never as a clock.

## Interface
Parameters:
- `DATA_W`, default 8: bits per transfer, MSB first; legal range 2..32.

Ports:
- `clk_in`, input, 1: system clock; all logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `clk_div`, input, 1: divider output, generated in the `clk_in` domain.
- `tx_data`, input, DATA_W: word to transmit.
- `tx_valid`, input, 1: request to start a transfer.
- `tx_ready`, output, 1: block is idle and will accept a word.
- `rx_data`, output, DATA_W: word received on `miso`; holds its value until the next transfer completes.
- `rx_valid`, output, 1: one-cycle pulse when `rx_data` is updated.
- `busy`, output, 1: a transfer is in progress.
- `sclk`, output, 1: SPI clock, mode 0 (idle low).
- `mosi`, output, 1: SPI data out.
- `miso`, input, 1: SPI data in.
- `cs_n`, output, 1: chip select, active low.

## Operation
- Tick generation:
  - `clk_div_q` registers `clk_div`.
  - `tick = clk_div ^ clk_div_q`, so both edges count.
  - One SCLK period equals one `clk_div` period.
- States:
  - **IDLE**: `cs_n`=1, `sclk`=0, `tx_ready`=1, `busy`=0. On `tx_valid && tx_ready`, latch `tx_data` into the shift register, drive `mosi`=MSB, `cs_n`=0, clear the bit counter, and go to SETUP. Ticks are ignored in IDLE.
  - **SETUP**: wait for one tick (CS-to-SCLK setup time), then go to SHIFT.
  - **SHIFT**:
    - Tick with `sclk`=0: drive `sclk`=1, shift `miso` into the RX register at the LSB, increment the counter.
    - Tick with `sclk`=1: drive `sclk`=0.
    - If counter < DATA_W after the falling edge, shift the TX register and present the next bit on `mosi`.
    - After the falling edge that follows the DATA_W-th rising edge, go to HOLD.
  - **HOLD**: wait for one tick, then go to IDLE. On that same edge: `cs_n`=1, `rx_data` is loaded from the RX register, and `rx_valid`=1 for one cycle.
- `tx_valid` while not in IDLE is ignored; it is not queued.
- `miso` is sampled on the same `clk_in` edge that raises `sclk`.
- Reset asserted during a transfer:
  - The next edge returns the block to IDLE with `cs_n`=1 and `sclk`=0.
  - No `rx_valid` pulse is produced.
  - `rx_data` is cleared.

## Timing
- Reset values: `tx_ready`=0 while `rst` is high and 1 on the first cycle after it drops; `busy`=0, `rx_valid`=0, `rx_data`=0, `sclk`=0, `mosi`=0, `cs_n`=1.
- A tick is detected one `clk_in` cycle after the `clk_div` transition.
- A transfer lasts exactly 2·DATA_W+2 ticks from acceptance to `cs_n` rising.
- With the divider at `div_step`=S, ticks occur every S+1 `clk_in` cycles.
- `tx_ready` returns to 1 on the cycle `rx_valid` pulses, so back-to-back transfers are possible.
- `cs_n` always stays high for at least one `clk_in` cycle between transfers.

## Configuration
- `SPI_LOOPBACK_EN`:
  - Defined: the RX shifter samples `mosi` internally and the `miso` port is ignored, so `rx_data` equals the transmitted word.
  - Undefined: the RX shifter samples `miso` normally.

## Structure
- Shared package `spi_pkg`:
  - State enumeration (IDLE/SETUP/SHIFT/HOLD).
  - `SPI_DATA_W_DEFAULT` = 8.
- One sub-module, `div_tick`: the register plus XOR edge detector on `clk_div`, with output `tick`. It is reusable by any other consumer of the divider.

## Test plan
- **Loopback byte.** Build with `SPI_LOOPBACK_EN`, `div_step`=3, `tx_data`=8'hA5. Required: 8 rising edges on `sclk`, `mosi` bits 1,0,1,0,0,1,0,1, `rx_data`=8'hA5, one `rx_valid` pulse, and `cs_n` low for 18 ticks (≈72 cycles).
- **External MISO.** Drive `miso` with pattern 8'h3C, changing on `sclk` falling edges. Required: `rx_data`=8'h3C.
- **Busy rejection.** Pulse `tx_valid` with 8'hFF mid-transfer. Required: it is ignored, and the output stream and `rx_data` reflect only the first word.
- **Back-to-back.** Hold `tx_valid` high with 8'h01 then 8'h80. Required: two transfers, `cs_n` high for ≥1 cycle between them, and two `rx_valid` pulses.
- **Reset mid-transfer.** Assert `rst` after the 4th `sclk` rise. Required: next cycle `cs_n`=1, `sclk`=0, `rx_data`=0, no `rx_valid`; `tx_ready`=1 after release.
- **Fastest divider.** Use `div_step`=0, giving a tick every cycle. Required: transfer completes in 18 ticks with correct data.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master path: the shift-engine state encoding
// and the default transfer width.
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_t;

endpackage

// File: rtl/div_tick.sv
// -----------------------------------------------------------------------------
// div_tick
// Edge detector for the clock divider output. clk_div is treated as a level
// generated in the clk_in domain; every transition (rising or falling) yields
// a one-cycle tick, so one clk_div period produces two ticks.
//
// Ports:
//   clk_in  - system clock
//   clk_div - divider output level (clk_in domain)
//   tick    - high for the clk_in cycle in which clk_div differs from its
//             registered copy
// -----------------------------------------------------------------------------
module div_tick (
  input  logic clk_in,
  input  logic clk_div,
  output logic tick
);

  logic r_clk_div_q;

  // The copy needs no reset: a spurious first tick is harmless to consumers
  // that ignore ticks while idle.
  always_ff @(posedge clk_in) begin
    r_clk_div_q <= clk_div;
  end

  assign tick = clk_div ^ r_clk_div_q;

endmodule

// File: rtl/spi_master_stage.sv
// -----------------------------------------------------------------------------
// spi_master_stage
// SPI mode-0 master shift engine driven by ticks derived from the divider
// output. Each tick is one SCLK half-period. A transfer takes 2*DATA_W+2 ticks
// from acceptance to cs_n rising: one setup tick, 2*DATA_W shift ticks and one
// hold tick. Data is MSB first.
//
// Build option:
//   SPI_LOOPBACK_EN - when defined, the receive shifter samples mosi
//                     internally and the miso port is ignored.
//
// Ports:
//   clk_in   - system clock, all logic on its rising edge
//   rst      - synchronous active-high reset
//   clk_div  - divider output level (sampled, never used as a clock)
//   tx_data  - word to transmit
//   tx_valid - request to start a transfer
//   tx_ready - idle and able to accept a word
//   rx_data  - last received word, held until the next completes
//   rx_valid - one-cycle pulse when rx_data updates
//   busy     - transfer in progress
//   sclk     - SPI clock, idle low
//   mosi     - SPI data out
//   miso     - SPI data in
//   cs_n     - chip select, active low
// -----------------------------------------------------------------------------
module spi_master_stage
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              clk_div,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  spi_state_t        r_state;
  spi_state_t        w_state_nxt;
  logic              w_tick;
  logic              w_accept;
  logic              w_rise;
  logic              w_fall;
  logic              w_done;
  logic              w_rx_bit;

  logic              r_sclk;
  logic              r_cs_n;
  logic              r_mosi;
  logic              r_rx_valid;
  logic [DATA_W-1:0] r_rx_data;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_tx_sr;
  logic [DATA_W-1:0] r_rx_sr;

  div_tick u_div_tick (
    .clk_in  (clk_in),
    .clk_div (clk_div),
    .tick    (w_tick)
  );

`ifdef SPI_LOOPBACK_EN
  logic w_miso_unused;
  assign w_miso_unused = miso;
  assign w_rx_bit      = r_mosi;
`else
  assign w_rx_bit      = miso;
`endif

  // State register
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle action strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Ticks are ignored here; only a host request moves us on.
        if (tx_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (w_tick) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_tick) begin
          if (!r_sclk) begin
            w_rise = 1'b1;
          end else begin
            w_fall = 1'b1;
            // Counter already reached DATA_W on the preceding rise.
            if (r_cnt == CNT_LAST) begin
              w_state_nxt = ST_HOLD;
            end
          end
        end
      end
      ST_HOLD: begin
        if (w_tick) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control outputs and bit counter
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_cnt      <= '0;
    end else begin
      r_rx_valid <= w_done;
      if (w_accept) begin
        r_mosi <= tx_data[DATA_W-1];
        r_cs_n <= 1'b0;
        r_cnt  <= '0;
      end
      if (w_rise) begin
        r_sclk <= 1'b1;
        r_cnt  <= r_cnt + 1'b1;
      end
      if (w_fall) begin
        r_sclk <= 1'b0;
        if (r_cnt < CNT_LAST) begin
          r_mosi <= r_tx_sr[DATA_W-2];
        end
      end
      if (w_done) begin
        r_cs_n    <= 1'b1;
        r_rx_data <= r_rx_sr;
      end
    end
  end

  // Shift registers: pure data, no reset needed
  always_ff @(posedge clk_in) begin
    if (w_accept) begin
      r_tx_sr <= tx_data;
    end else if (w_fall && (r_cnt < CNT_LAST)) begin
      r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
    end
    if (w_rise) begin
      r_rx_sr <= {r_rx_sr[DATA_W-2:0], w_rx_bit};
    end
  end

  assign tx_ready = (r_state == ST_IDLE) && !rst;
  assign busy     = (r_state != ST_IDLE);
  assign sclk     = r_sclk;
  assign cs_n     = r_cs_n;
  assign mosi     = r_mosi;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule
